alu_operand_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 24 ++
 rtl/add_8bit.sv | 17 +
 rtl/alu_operand_stage.sv | 159 +++++++++++++++
 tb/tb_alu_operand_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM encoding and flag bit positions for the ALU operand stage
package alu_pkg;

  localparam logic [2:0] OP_LDA  = 3'd0;
  localparam logic [2:0] OP_LDB  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_ADDI = 3'd4;
  localparam logic [2:0] OP_SUBI = 3'd5;
  localparam logic [2:0] OP_CMP  = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;

endpackage

// File: rtl/add_8bit.sv
// rtl/add_8bit.sv - 8-bit add/sub datapath; sel=1 computes a + ~b + 1
module add_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sel,
  output logic [7:0] z,
  output logic       cout
);

  logic [7:0] b_eff;

  always_comb begin
    b_eff     = b ^ {8{sel}};
    {cout, z} = {1'b0, a} + {1'b0, b_eff} + {8'd0, sel};
  end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - A/B registers and 3-cycle command sequencer around add_8bit
// Define ALU_OVERFLOW_FLAG_EN to build the signed-overflow flag V (flags[3]).
module alu_operand_stage
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       res_valid,
  output logic [7:0] acc,
  output logic [3:0] flags
);

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [7:0] data_q, data_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       c_q, c_d;
  logic       z_q, z_d;
  logic       n_q, n_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       res_valid_q, res_valid_d;

  logic [7:0] add_b;
  logic       add_sel;
  logic [7:0] add_z;
  logic       add_cout;

  // Operands come only from registers, so the adder output is stable through EXEC and WB.
  always_comb begin
    add_b   = ((op_q == OP_ADDI) || (op_q == OP_SUBI)) ? data_q : b_q;
    add_sel = (op_q == OP_SUB) || (op_q == OP_SUBI) || (op_q == OP_CMP);
  end

  add_8bit u_add (
    .a    (a_q),
    .b    (add_b),
    .sel  (add_sel),
    .z    (add_z),
    .cout (add_cout)
  );

`ifdef ALU_OVERFLOW_FLAG_EN
  logic       v_q, v_d;
  logic [7:0] b_eff;

  always_comb begin
    b_eff = add_b ^ {8{add_sel}};
    v_d   = v_q;
    if (state_q == ST_WB) begin
      if (op_q == OP_CLR) begin
        v_d = 1'b0;
      end else if ((op_q != OP_LDA) && (op_q != OP_LDB)) begin
        v_d = (a_q[7] == b_eff[7]) && (add_z[7] != a_q[7]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= 1'b0;
    end else begin
      v_q <= v_d;
    end
  end
`else
  logic v_q;
  assign v_q = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    z_d     = z_q;
    n_d     = n_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        state_d = ST_IDLE;
        case (op_q)
          OP_LDA: a_d = data_q;
          OP_LDB: b_d = data_q;
          OP_CLR: begin
            a_d = 8'd0;
            b_d = 8'd0;
            c_d = 1'b0;
            z_d = 1'b0;
            n_d = 1'b0;
          end
          default: begin
            if (op_q != OP_CMP) begin
              a_d = add_z;
            end
            c_d = add_cout;
            z_d = (add_z == 8'd0);
            n_d = add_z[7];
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
    res_valid_d = (state_d == ST_WB);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LDA;
      data_q      <= 8'd0;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      z_q         <= z_d;
      n_q         <= n_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
    end
  end

  always_comb begin
    flags        = 4'd0;
    flags[FLG_C] = c_q;
    flags[FLG_Z] = z_q;
    flags[FLG_N] = n_q;
    flags[FLG_V] = v_q;
  end

  assign cmd_ready = cmd_ready_q;
  assign res_valid = res_valid_q;
  assign acc       = a_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - scoreboard bench for alu_operand_stage
module tb_alu_operand_stage;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       res_valid;
  logic [7:0] acc;
  logic [3:0] flags;

  alu_operand_stage dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .res_valid (res_valid),
    .acc       (acc),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] acc;
    logic [3:0] flags;
    int         acc_edge;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] m_a = 8'd0;
  logic [7:0] m_b = 8'd0;
  logic [3:0] m_f = 4'd0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural registers.
  task automatic push(input logic [2:0] op, input logic [7:0] d, input int e_edge);
    exp_t e;
    int ai, bi, r, sa, sb, sr;
    logic c, v;
    logic [7:0] res;
    case (op)
      OP_LDA: m_a = d;
      OP_LDB: m_b = d;
      OP_CLR: begin m_a = 8'd0; m_b = 8'd0; m_f = 4'd0; end
      default: begin
        ai = int'(m_a);
        bi = ((op == OP_ADDI) || (op == OP_SUBI)) ? int'(d) : int'(m_b);
        sa = (ai > 127) ? ai - 256 : ai;
        sb = (bi > 127) ? bi - 256 : bi;
        if ((op == OP_SUB) || (op == OP_SUBI) || (op == OP_CMP)) begin
          r  = ai - bi;
          sr = sa - sb;
          c  = (ai >= bi);
        end else begin
          r  = ai + bi;
          sr = sa + sb;
          c  = (r > 255);
        end
        res = r[7:0];
`ifdef ALU_OVERFLOW_FLAG_EN
        v = (sr > 127) || (sr < -128);
`else
        v = 1'b0;
`endif
        m_f = {v, res[7], (res == 8'd0), c};
        if (op != OP_CMP) m_a = res;
      end
    endcase
    e.acc      = m_a;
    e.flags    = m_f;
    e.acc_edge = e_edge;
    exp_q.push_back(e);
  endtask

  // Monitor: res_valid must arrive one edge after the accept; results land on the following edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && res_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_res_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("res_valid_latency", cyc, e.acc_edge + 1);
        @(posedge clk);
        #1;
        check("acc", int'(acc), int'(e.acc));
        check("flags", int'(flags), int'(e.flags));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [7:0] d);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_issue", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    push(op, d, cyc + 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_data  = 8'($urandom);
    check("ready_in_exec", int'(cmd_ready), 0);
    @(negedge clk);
    check("ready_in_wb", int'(cmd_ready), 0);
    @(negedge clk);
    check("ready_after_wb", int'(cmd_ready), 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int accepts;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 8'd0;
    repeat (2) @(negedge clk);
    check("reset_acc", int'(acc), 0);
    check("reset_flags", int'(flags), 0);
    check("reset_cmd_ready", int'(cmd_ready), 1);
    check("reset_res_valid", int'(res_valid), 0);
    rst = 1'b0;
    @(negedge clk);

    issue(OP_LDA, 8'h05); issue(OP_LDB, 8'h03); issue(OP_ADD, 8'h00);
    drain();
    check("add_acc", int'(acc), 8'h08);
    check("add_flags", int'(flags), 4'b0000);

    issue(OP_LDA, 8'h05); issue(OP_LDB, 8'h05); issue(OP_SUB, 8'h00);
    drain();
    check("sub_acc", int'(acc), 8'h00);
    check("sub_flags", int'(flags), 4'b0011);

    issue(OP_LDA, 8'h03); issue(OP_SUBI, 8'h05);
    drain();
    check("subi_acc", int'(acc), 8'hFE);
    check("subi_flags", int'(flags), 4'b0100);

    issue(OP_LDA, 8'h7F); issue(OP_ADDI, 8'h01);
    drain();
    check("addi_acc", int'(acc), 8'h80);
`ifdef ALU_OVERFLOW_FLAG_EN
    check("addi_flags", int'(flags), 4'b1100);
`else
    check("addi_flags", int'(flags), 4'b0100);
`endif

    issue(OP_LDA, 8'h10); issue(OP_LDB, 8'h20); issue(OP_CMP, 8'h00);
    drain();
    check("cmp_acc", int'(acc), 8'h10);
    check("cmp_flags", int'(flags), 4'b0100);

    // Valid held for 5 cycles: only the cycles where the stage is idle may accept.
    accepts   = 0;
    cmd_valid = 1'b1;
    cmd_op    = OP_ADDI;
    cmd_data  = 8'h01;
    for (int i = 0; i < 5; i++) begin
      if (cmd_ready) begin
        push(OP_ADDI, 8'h01, cyc + 1);
        accepts++;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("hold_accepts", accepts, 2);
    drain();
    check("hold_acc", int'(acc), 8'h12);

    issue(OP_LDA, 8'h03); issue(OP_SUBI, 8'h05);
    drain();
    check("pre_reset_acc", int'(acc), 8'hFE);
    cmd_valid = 1'b1;
    cmd_op    = OP_ADD;
    cmd_data  = 8'h00;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("abort_in_exec", int'(cmd_ready), 0);
    rst = 1'b1;
    #1;
    check("abort_acc", int'(acc), 0);
    check("abort_flags", int'(flags), 0);
    check("abort_res_valid", int'(res_valid), 0);
    m_a = 8'd0; m_b = 8'd0; m_f = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_after", int'(cmd_ready), 1);
    repeat (3) @(negedge clk);
    check("abort_acc_after", int'(acc), 0);

    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), 8'($urandom));
    end
    drain();
    issue(OP_CLR, 8'h00);
    drain();
    check("clr_acc", int'(acc), 0);
    check("clr_flags", int'(flags), 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
